core_mc_ctrl: RTL
=================

CORE_MC_CTRL -- requirements
Module: core_mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port ir, input, 32, current instruction register contents.
REQ-004 SHALL have port br_taken, input, 1, branch comparator result for the instruction in ir.
REQ-005 SHALL have port mem_ready, input, 1, memory accepts/completes the current request this cycle.
REQ-006 SHALL have port mem_req, output, 1, memory request valid.
REQ-007 SHALL have port mem_we, output, 1, request is a store; meaningful only with mem_req.
REQ-008 SHALL have port mem_ifetch, output, 1, request is an instruction fetch (address = PC).
REQ-009 SHALL have port ir_we, output, 1, load fetched word into IR this edge.
REQ-010 SHALL have port pc_we, output, 1, update PC this edge.
REQ-011 SHALL have port pc_src, output, 2, PC source: 0 = PC+4, 1 = PC+imm, 2 = (rs1+imm)&~1.
REQ-012 SHALL have port rf_we, output, 1, register file write enable.
REQ-013 SHALL have port wb_sel, output, 2, writeback source: 0 = ALU, 1 = load data, 2 = PC+4.
REQ-014 SHALL have port retire, output, 1, one-cycle pulse per completed instruction.
REQ-015 SHALL have port trap, output, 1, sticky illegal/system-instruction halt flag.

Function
REQ-016 SHALL implement a registered FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs decoded combinationally from state, ir, br_taken, mem_ready.
REQ-017 Opcode class SHALL come from ir[6:2] using rv::OPCODE_* (OPIMM, OP 5'b01100, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM, MISCMEM 5'b00011).
REQ-018 FETCH: mem_req=1, mem_ifetch=1, mem_we=0; when mem_ready=1, ir_we=1 and next state DECODE; otherwise stay, ir_we=0.
REQ-019 DECODE: if ir[1:0]!=2'b11 or opcode not in REQ-017 list or opcode=SYSTEM -> HALT; else -> EXEC; no enables asserted.
REQ-020 EXEC, OP/OPIMM/LUI/AUIPC/JAL/JALR -> WB; LOAD/STORE -> MEM.
REQ-021 EXEC, BRANCH: pc_we=1, pc_src=1 if br_taken else 0, retire=1, -> FETCH.
REQ-022 EXEC, MISCMEM: treated as NOP; pc_we=1, pc_src=0, retire=1, -> FETCH.
REQ-023 MEM: mem_req=1, mem_ifetch=0, mem_we=1 for STORE else 0; stay while mem_ready=0; on mem_ready: LOAD -> WB; STORE -> pc_we=1, pc_src=0, retire=1, -> FETCH.
REQ-024 WB: rf_we=1, pc_we=1, retire=1, -> FETCH; wb_sel=1 for LOAD, 2 for JAL/JALR, else 0; pc_src=1 for JAL, 2 for JALR, else 0.
REQ-025 rf_we SHALL be asserted regardless of rd (x0 suppression lives in the register file).
REQ-026 HALT: trap=1, all other outputs 0; stay until reset.
REQ-027 Outputs not specified for a state SHALL be 0 (pc_src/wb_sel = 0).
REQ-028 Latency: ALU/LUI/AUIPC/JAL/JALR = 4 cycles, branch/fence = 3, load = 5, store = 4, each plus memory wait cycles.
REQ-029 mem_ready while mem_req=0 SHALL be ignored; mem_req SHALL remain high and stable until mem_ready.
REQ-030 ir SHALL be stable from DECODE through retirement; no internal copy of ir.

Reset
REQ-031 rst=1 SHALL force state FETCH asynchronously and hold all outputs 0, including mem_req and trap.
REQ-032 First cycle after rst deasserts SHALL present mem_req=1, mem_ifetch=1.
REQ-033 rst mid-instruction (any state incl. MEM with store pending, HALT) SHALL abandon it with no pc_we, rf_we or retire.

Verification
REQ-034 ADDI, mem_ready=1 always -> FETCH,DECODE,EXEC,WB; WB: rf_we=1, wb_sel=0, pc_we=1, pc_src=0, retire=1.
REQ-035 Load, mem_ready low 2 cycles in FETCH and 3 in MEM -> mem_req held high throughout, wb_sel=1 in WB, total 10 cycles.
REQ-036 BEQ with br_taken=1 then br_taken=0 -> EXEC pc_src=1 then 0, pc_we=1, rf_we=0, 3 cycles each.
REQ-037 JALR -> WB: rf_we=1, wb_sel=2, pc_src=2; store -> MEM mem_we=1, no rf_we.
REQ-038 ir=32'h00000073 (ECALL) or ir[1:0]=2'b00 -> HALT after DECODE, trap=1 sticky, mem_req=0; rst -> trap=0, fetch resumes.
REQ-039 rst asserted in MEM with store pending -> mem_req drops immediately, no retire; restart at FETCH.

Source files
------------

// File: rtl/core_mc_ctrl.sv
// core_mc_ctrl: multicycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback
module core_mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_ifetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap
);
  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_MISCMEM = 5'b00011;
  localparam logic [4:0] OPCODE_OPIMM   = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_OP      = 5'b01100;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nxt;

  logic [4:0] op;
  logic is_load, is_store, is_branch, is_jal, is_jalr, is_misc, is_wbop, legal;
  logic unused;

  assign op        = ir[6:2];
  assign is_load   = op == OPCODE_LOAD;
  assign is_store  = op == OPCODE_STORE;
  assign is_branch = op == OPCODE_BRANCH;
  assign is_jal    = op == OPCODE_JAL;
  assign is_jalr   = op == OPCODE_JALR;
  assign is_misc   = op == OPCODE_MISCMEM;
  assign is_wbop   = op == OPCODE_OPIMM || op == OPCODE_OP || op == OPCODE_LUI ||
                     op == OPCODE_AUIPC || is_jal || is_jalr;
  // SYSTEM and every unlisted opcode fall outside this set and end in HALT
  assign legal     = ir[1:0] == 2'b11 && (is_wbop || is_load || is_store || is_branch || is_misc);
  assign unused    = ^ir[31:7];

  // state register; reset returns to FETCH immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else     state <= state_nxt;

  // next state and outputs; all outputs held low while rst is high
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_ifetch = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    rf_we      = 1'b0;
    wb_sel     = 2'd0;
    retire     = 1'b0;
    trap       = 1'b0;
    if (!rst)
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          ir_we      = mem_ready;
          state_nxt  = mem_ready ? DECODE : FETCH;
        end
        DECODE: state_nxt = legal ? EXEC : HALT;
        EXEC:
          if (is_branch || is_misc) begin
            pc_we     = 1'b1;
            pc_src    = (is_branch && br_taken) ? 2'd1 : 2'd0;
            retire    = 1'b1;
            state_nxt = FETCH;
          end else
            state_nxt = (is_load || is_store) ? MEM : WB;
        MEM: begin
          mem_req = 1'b1;
          mem_we  = is_store;
          if (mem_ready) begin
            pc_we     = is_store;
            retire    = is_store;
            state_nxt = is_store ? FETCH : WB;
          end
        end
        WB: begin
          rf_we     = 1'b1;
          pc_we     = 1'b1;
          retire    = 1'b1;
          wb_sel    = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
          pc_src    = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
          state_nxt = FETCH;
        end
        HALT: trap = 1'b1;
        default: state_nxt = FETCH;
      endcase
  end
endmodule
